beehive_out_convert: RTL and testbench
======================================

Name: beehive_out_convert

Overview:
- Transmit-side bridge from the Beehive narrow MAC stream to the wide AXIS sync TX interface of the NIC app block.
- Packs `MAC_INTERFACE_W` beats into AXIS_SYNC_DATA_WIDTH words and converts Beehive padbytes to AXIS tkeep.
- Flips bus endianness: Beehive byte 0 sits at the MSB; AXIS byte 0 sits at bits [7:0].
- Sits between the Beehive TX engine and the app_axis_sync_tx port.

Parameters:
AXIS_SYNC_DATA_WIDTH, 512, AXIS tdata width; must be a multiple of `MAC_INTERFACE_W (generate-time $error otherwise)
AXIS_SYNC_KEEP_WIDTH, AXIS_SYNC_DATA_WIDTH/8, AXIS tkeep width
AXIS_SYNC_TX_USER_WIDTH, 1, AXIS tuser width

Derived constants: RATIO = AXIS_SYNC_DATA_WIDTH/`MAC_INTERFACE_W; NB = `MAC_INTERFACE_W/8.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
src_convert_tx_val  input  1  Beehive beat valid
src_convert_tx_data  input  `MAC_INTERFACE_W  beat data; Beehive byte 0 at MSB
src_convert_tx_last  input  1  last beat of frame
src_convert_tx_padbytes  input  `MAC_PADBYTES_W  unused trailing bytes on the last beat; 0 = full beat
convert_src_tx_rdy  output  1  beat accepted when val & rdy
app_axis_sync_tx_tvalid  output  1  AXIS valid
app_axis_sync_tx_tdata  output  AXIS_SYNC_DATA_WIDTH  AXIS data; byte 0 at [7:0]
app_axis_sync_tx_tkeep  output  AXIS_SYNC_KEEP_WIDTH  AXIS byte enables
app_axis_sync_tx_tlast  output  1  AXIS end of packet
app_axis_sync_tx_tuser  output  AXIS_SYNC_TX_USER_WIDTH  always 0
app_axis_sync_tx_tready  input  1  AXIS ready

Behaviour:
- State:
  - Accumulator: data buffer and Beehive-order keep buffer, both AXIS width.
  - idx counter: 0..RATIO-1.
  - Output register holding tdata/tkeep/tlast/tvalid.
- Reset (async): tvalid=0, tdata=0, tkeep=0, tlast=0, idx=0, accumulator cleared. tuser is constant 0.
- rdy: convert_src_tx_rdy = ~tvalid | tready (combinational). Reads 1 during reset.
- Per accepted beat:
  - Beat placement: the beat lands in Beehive-order slot idx, i.e. bytes idx*NB..idx*NB+NB-1 counted from the MSB.
  - Beat keep: top NB-padbytes bits set, MSB-first. padbytes is honoured only when last=1; on non-last beats it is treated as 0.
  - Completion condition: the beat completes the word when idx==RATIO-1 or last==1.
    - If complete: load the output register from accumulator merged with the current beat. Unfilled slots carry data 0 and keep 0. Set tvalid=1, tlast=last. Clear the accumulator and set idx=0.
    - Otherwise: write the beat into the accumulator and increment idx.
- Output mapping: tdata = byte-flipped wide word; tkeep = bit-flipped wide keep.
- Output handshake:
  - When tvalid & tready and no new word loads this cycle, tvalid drops to 0 next cycle.
  - A simultaneous drain and load keeps tvalid=1 with the new contents.
- Stability: while tvalid & ~tready, tdata/tkeep/tlast are held stable and no input beat is accepted.
- Latency: a completing beat appears on AXIS the cycle after acceptance.
- Throughput: with tready=1, one Beehive beat per cycle is sustained.
- Frame boundaries: a new frame always starts at idx=0; words never mix two frames.
- RATIO==1: every beat completes a word; the design remains registered with 1-cycle latency.
- Input with val=0 leaves all state unchanged. There is no timeout: a partial word waits indefinitely for further beats.
- Reset mid-frame: the partial word and any pending output are discarded. The next accepted beat is treated as slot 0 of a new frame.

Test Plan (`MAC_INTERFACE_W=256, AXIS 512, NB=32, RATIO=2):
- 2 beats, bytes 0x00..0x3F, last padbytes=0 -> one AXIS beat with tkeep=64'hFFFF_FFFF_FFFF_FFFF, tlast=1, tdata[7:0]=0x00, tdata[511:504]=0x3F.
- 3 beats, last padbytes=22 -> first AXIS beat: tkeep all-ones, tlast=0. Second AXIS beat: tkeep=64'h0000_0000_0000_03FF, tlast=1, tdata[511:80]=0.
- 1-beat frame, padbytes=31 -> tkeep=64'h1, tlast=1. Also padbytes=7 on a non-last beat is ignored (full keep).
- tready held 0 for 5 cycles while tvalid=1 -> tdata/tkeep/tlast stable, rdy=0, no beats accepted. On release, every beat appears exactly once, in order.
- 3 back-to-back 4-beat frames, tready=1, val=1 continuously -> rdy never drops. 6 AXIS beats with tlast on the 2nd, 4th and 6th.
- rst pulsed asynchronously after 1 beat of a frame -> tvalid=0 immediately. A following 2-beat frame produces a single full-keep beat with correct byte order.

Source files
------------

// File: rtl/beehive_out_convert.sv
// Beehive narrow TX stream -> wide AXIS sync TX bridge.
// Packs MAC beats into AXIS words, turns padbytes into tkeep and flips the
// byte order so that Beehive byte 0 (MSB) lands on AXIS byte 0 (bits [7:0]).

`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

module beehive_out_convert #(
    parameter int AXIS_SYNC_DATA_WIDTH    = 512,
    parameter int AXIS_SYNC_KEEP_WIDTH    = AXIS_SYNC_DATA_WIDTH/8,
    parameter int AXIS_SYNC_TX_USER_WIDTH = 1
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic                               src_convert_tx_val,
    input  logic [`MAC_INTERFACE_W-1:0]        src_convert_tx_data,
    input  logic                               src_convert_tx_last,
    input  logic [`MAC_PADBYTES_W-1:0]         src_convert_tx_padbytes,
    output logic                               convert_src_tx_rdy,

    output logic                               app_axis_sync_tx_tvalid,
    output logic [AXIS_SYNC_DATA_WIDTH-1:0]    app_axis_sync_tx_tdata,
    output logic [AXIS_SYNC_KEEP_WIDTH-1:0]    app_axis_sync_tx_tkeep,
    output logic                               app_axis_sync_tx_tlast,
    output logic [AXIS_SYNC_TX_USER_WIDTH-1:0] app_axis_sync_tx_tuser,
    input  logic                               app_axis_sync_tx_tready
);

    localparam int MAC_W = `MAC_INTERFACE_W;
    localparam int NB    = MAC_W/8;
    localparam int DW    = AXIS_SYNC_DATA_WIDTH;
    localparam int KW    = AXIS_SYNC_KEEP_WIDTH;
    localparam int RATIO = DW/MAC_W;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((DW % MAC_W) != 0) begin : g_width_chk
        $error("AXIS_SYNC_DATA_WIDTH must be a multiple of MAC_INTERFACE_W");
    end

    // Accumulator in Beehive order: slot 0 at the MSB end.
    logic [DW-1:0]    acc_data;
    logic [KW-1:0]    acc_keep;
    logic [IDX_W-1:0] idx;

    logic [`MAC_PADBYTES_W-1:0] eff_pad;
    logic [NB-1:0]              beat_keep;
    logic [MAC_W-1:0]           beat_data;
    logic [DW-1:0]              mrg_data;
    logic [KW-1:0]              mrg_keep;
    logic [DW-1:0]              flip_data;
    logic [KW-1:0]              flip_keep;
    logic                       accept;
    logic                       complete;

    assign convert_src_tx_rdy     = ~app_axis_sync_tx_tvalid | app_axis_sync_tx_tready;
    assign accept                 = src_convert_tx_val & convert_src_tx_rdy;
    assign complete               = src_convert_tx_last | (idx == IDX_W'(RATIO-1));
    assign app_axis_sync_tx_tuser = '0;

    // Padbytes only matter on the last beat; keep is MSB-first (byte 0 = top bit).
    assign eff_pad   = src_convert_tx_last ? src_convert_tx_padbytes : '0;
    assign beat_keep = {NB{1'b1}} << eff_pad;

    // Zero the padded bytes so invalid lanes never leak stale data.
    for (genvar b = 0; b < NB; b++) begin : g_mask
        assign beat_data[MAC_W-1-8*b -: 8] = src_convert_tx_data[MAC_W-1-8*b -: 8]
                                           & {8{beat_keep[NB-1-b]}};
    end

    // Drop the current beat into slot idx; other slots come from the accumulator.
    for (genvar s = 0; s < RATIO; s++) begin : g_slot
        assign mrg_data[DW-1-s*MAC_W -: MAC_W] = (idx == IDX_W'(s)) ? beat_data
                                               : acc_data[DW-1-s*MAC_W -: MAC_W];
        assign mrg_keep[KW-1-s*NB -: NB]       = (idx == IDX_W'(s)) ? beat_keep
                                               : acc_keep[KW-1-s*NB -: NB];
    end

    // Endianness flip: Beehive byte i (from MSB) -> AXIS byte i (from LSB).
    for (genvar i = 0; i < KW; i++) begin : g_flip
        assign flip_data[8*i +: 8] = mrg_data[DW-1-8*i -: 8];
        assign flip_keep[i]        = mrg_keep[KW-1-i];
    end

    // Accumulate beats; a completing beat clears the accumulator for the next word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_data <= '0;
            acc_keep <= '0;
            idx      <= '0;
        end else if (accept) begin
            if (complete) begin
                acc_data <= '0;
                acc_keep <= '0;
                idx      <= '0;
            end else begin
                acc_data <= mrg_data;
                acc_keep <= mrg_keep;
                idx      <= idx + IDX_W'(1);
            end
        end
    end

    // Output register: load on a completing beat, drop valid once drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            app_axis_sync_tx_tvalid <= 1'b0;
            app_axis_sync_tx_tdata  <= '0;
            app_axis_sync_tx_tkeep  <= '0;
            app_axis_sync_tx_tlast  <= 1'b0;
        end else if (accept && complete) begin
            app_axis_sync_tx_tvalid <= 1'b1;
            app_axis_sync_tx_tdata  <= flip_data;
            app_axis_sync_tx_tkeep  <= flip_keep;
            app_axis_sync_tx_tlast  <= src_convert_tx_last;
        end else if (app_axis_sync_tx_tready) begin
            app_axis_sync_tx_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_beehive_out_convert.sv
// Directed bench for beehive_out_convert (256-bit MAC, 512-bit AXIS).

`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

module tb_beehive_out_convert;

    localparam logic [63:0] KEEP_ALL = {64{1'b1}};

    logic         clk;
    logic         rst;
    logic         val;
    logic [255:0] data;
    logic         last;
    logic [4:0]   pad;
    logic         rdy;
    logic         tvalid;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic         tlast;
    logic [0:0]   tuser;
    logic         tready;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
    } ax_t;

    ax_t q[$];
    int  n_cmp    = 0;
    int  n_bad    = 0;
    int  n_acc    = 0;
    int  rdy_drop = 0;

    beehive_out_convert #(
        .AXIS_SYNC_DATA_WIDTH    (512),
        .AXIS_SYNC_KEEP_WIDTH    (64),
        .AXIS_SYNC_TX_USER_WIDTH (1)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .src_convert_tx_val      (val),
        .src_convert_tx_data     (data),
        .src_convert_tx_last     (last),
        .src_convert_tx_padbytes (pad),
        .convert_src_tx_rdy      (rdy),
        .app_axis_sync_tx_tvalid (tvalid),
        .app_axis_sync_tx_tdata  (tdata),
        .app_axis_sync_tx_tkeep  (tkeep),
        .app_axis_sync_tx_tlast  (tlast),
        .app_axis_sync_tx_tuser  (tuser),
        .app_axis_sync_tx_tready (tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at posedge+1, so negedge sees what the next posedge will use.
    always @(negedge clk) begin
        ax_t e;
        if (tvalid && tready) begin
            e.d = tdata;
            e.k = tkeep;
            e.l = tlast;
            q.push_back(e);
        end
        if (val && rdy && !rst) n_acc++;
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beehive beat: byte k at the MSB end, n valid bytes counting up from base.
    function automatic logic [255:0] mk_beat(input int base, input int n);
        logic [255:0] b;
        b = '0;
        for (int k = 0; k < n; k++) b[255-8*k -: 8] = 8'(base + k);
        return b;
    endfunction

    // AXIS word: byte i at bits [8i+7:8i].
    function automatic logic [511:0] mk_word(input int base, input int n);
        logic [511:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = 8'(base + i);
        return w;
    endfunction

    task automatic send_beat(input logic [255:0] d, input logic l, input logic [4:0] p);
        bit ok;
        int tries;
        @(posedge clk); #1;
        val = 1'b1; data = d; last = l; pad = p;
        ok = 0;
        tries = 0;
        while (!ok && tries < 50) begin
            @(negedge clk);
            if (rdy) ok = 1;
            else rdy_drop++;
            tries++;
        end
        if (!ok) chk("beat_accept_timeout", 0, 1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        val = 1'b0; data = '0; last = 1'b0; pad = '0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (tvalid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (tvalid) chk("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic expect_word(input string tag, input logic [511:0] d,
                               input logic [63:0] k, input logic l);
        ax_t e;
        if (q.size() == 0) begin
            chk({tag, "_present"}, 0, 1);
        end else begin
            e = q.pop_front();
            chk({tag, "_data"}, e.d, d);
            chk({tag, "_keep"}, {448'd0, e.k}, {448'd0, k});
            chk({tag, "_last"}, {511'd0, e.l}, {511'd0, l});
        end
    endtask

    task automatic pulse_rst();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_async_tvalid", {511'd0, tvalid}, 512'd0);
        chk("rst_async_tkeep", {448'd0, tkeep}, 512'd0);
        chk("rst_async_rdy", {511'd0, rdy}, 512'd1);
        rst = 1'b0;
    endtask

    initial begin
        int base_acc;
        rst = 1'b0; val = 1'b0; data = '0; last = 1'b0; pad = '0; tready = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("reset_tvalid", {511'd0, tvalid}, 512'd0);
        chk("reset_tdata", tdata, 512'd0);
        chk("reset_tkeep", {448'd0, tkeep}, 512'd0);
        chk("reset_tlast", {511'd0, tlast}, 512'd0);
        chk("reset_tuser", {511'd0, tuser}, 512'd0);
        chk("reset_rdy", {511'd0, rdy}, 512'd1);
        #10 rst = 1'b0;

        // Two full beats -> one full word, visible the cycle after the last beat.
        send_beat(mk_beat(8'h00, 32), 1'b0, 5'd0);
        send_beat(mk_beat(8'h20, 32), 1'b1, 5'd0);
        idle();
        chk("t1_latency_tvalid", {511'd0, tvalid}, 512'd1);
        chk("t1_byte0", {504'd0, tdata[7:0]}, 512'h00);
        chk("t1_byte63", {504'd0, tdata[511:504]}, 512'h3F);
        wait_drain();
        expect_word("t1", mk_word(8'h00, 64), KEEP_ALL, 1'b1);

        // Three beats, last with 22 padbytes -> second word keeps 10 bytes.
        send_beat(mk_beat(8'h00, 32), 1'b0, 5'd0);
        send_beat(mk_beat(8'h20, 32), 1'b0, 5'd0);
        send_beat(mk_beat(8'h40, 10), 1'b1, 5'd22);
        idle();
        wait_drain();
        chk("t2_count", q.size(), 2);
        expect_word("t2_w0", mk_word(8'h00, 64), KEEP_ALL, 1'b0);
        expect_word("t2_w1", mk_word(8'h40, 10), 64'h0000_0000_0000_03FF, 1'b1);

        // One-byte frame; then padbytes on a non-last beat must be ignored.
        send_beat(mk_beat(8'h80, 1), 1'b1, 5'd31);
        send_beat(mk_beat(8'h90, 32), 1'b0, 5'd7);
        send_beat(mk_beat(8'hB0, 32), 1'b1, 5'd0);
        idle();
        wait_drain();
        expect_word("t3_one", mk_word(8'h80, 1), 64'h1, 1'b1);
        expect_word("t3_nlpad", mk_word(8'h90, 64), KEEP_ALL, 1'b1);

        // Backpressure: output held, no beats accepted while tready=0.
        @(posedge clk); #1 tready = 1'b0;
        send_beat(mk_beat(8'h10, 32), 1'b0, 5'd0);
        send_beat(mk_beat(8'h30, 32), 1'b1, 5'd0);
        @(posedge clk); #1;
        val = 1'b1; data = mk_beat(8'h50, 32); last = 1'b0; pad = '0;
        base_acc = n_acc;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_hold_data", tdata, mk_word(8'h10, 64));
            chk("t4_hold_keep", {448'd0, tkeep}, {448'd0, KEEP_ALL});
            chk("t4_hold_last", {511'd0, tlast}, 512'd1);
            chk("t4_hold_rdy", {511'd0, rdy}, 512'd0);
            chk("t4_hold_acc", n_acc, base_acc);
        end
        @(posedge clk); #1 tready = 1'b1;
        @(negedge clk);
        send_beat(mk_beat(8'h70, 32), 1'b1, 5'd0);
        idle();
        wait_drain();
        chk("t4_accepted", n_acc, base_acc + 2);
        chk("t4_count", q.size(), 2);
        expect_word("t4_a", mk_word(8'h10, 64), KEEP_ALL, 1'b1);
        expect_word("t4_b", mk_word(8'h50, 64), KEEP_ALL, 1'b1);

        // Three back-to-back 4-beat frames at full rate.
        rdy_drop = 0;
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < 4; b++)
                send_beat(mk_beat(f*16 + b*32, 32), (b == 3), 5'd0);
        idle();
        wait_drain();
        chk("t5_rdy_drops", rdy_drop, 0);
        chk("t5_count", q.size(), 6);
        for (int f = 0; f < 3; f++) begin
            expect_word($sformatf("t5_f%0d_w0", f), mk_word(f*16, 64), KEEP_ALL, 1'b0);
            expect_word($sformatf("t5_f%0d_w1", f), mk_word(f*16 + 64, 64), KEEP_ALL, 1'b1);
        end

        // Async reset drops a pending output word.
        @(posedge clk); #1 tready = 1'b0;
        send_beat(mk_beat(8'hC0, 32), 1'b1, 5'd0);
        idle();
        chk("t6_pending", {511'd0, tvalid}, 512'd1);
        pulse_rst();
        // Async reset discards a partial word; next beat restarts at slot 0.
        send_beat(mk_beat(8'hEE, 32), 1'b0, 5'd0);
        idle();
        pulse_rst();
        @(posedge clk); #1 tready = 1'b1;
        q.delete();
        send_beat(mk_beat(8'h00, 32), 1'b0, 5'd0);
        send_beat(mk_beat(8'h20, 32), 1'b1, 5'd0);
        idle();
        wait_drain();
        chk("t6_count", q.size(), 1);
        expect_word("t6_after_rst", mk_word(8'h00, 64), KEEP_ALL, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
